// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_pkg
//  Purpose  : Shared types and constants for the unified memory port arbiter
//             (FSM state encodings, cache port ids, default error data).
//  Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Arbiter FSM states; 2'b11 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BUSY    = 2'b01,
        ST_RECOVER = 2'b10
    } state_t;

    // Cache port identifiers, also used as request/grant bit positions.
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Read data handed back when the watchdog forces a completion.
    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Two-way round-robin pick: a lone requester wins, a tie goes to the
    // port that did not win last time.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        logic pick;
        pick = GNT_I;
        case (req)
            2'b01:   pick = GNT_I;
            2'b10:   pick = GNT_D;
            2'b11:   pick = ~last;
            default: pick = GNT_I;
        endcase
        return pick;
    endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_if
//  Purpose  : Request/ready memory port bundle. The requester side is the
//             master; the responder side is the slave. Used for both cache
//             ports (arbiter = slave) and the backing memory (arbiter = master).
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;

    logic        req;    // request, level
    logic [31:0] addr;   // memory address
    logic        we;     // write enable
    logic [31:0] wd;     // write data
    logic        ready;  // completion pulse
    logic [31:0] rd;     // read data, valid with ready

    modport master (
        output req,
        output addr,
        output we,
        output wd,
        input  ready,
        input  rd
    );

    modport slave (
        input  req,
        input  addr,
        input  we,
        input  wd,
        output ready,
        output rd
    );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way round-robin arbiter. Combinational grant from the
//             current requests and the last-granted register; the register
//             takes the new grant whenever advance is pulsed.
//  Revision : 1.0 - initial release
// ============================================================================
import mem_port_arbiter_pkg::*;

module rr_arb2 (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic [1:0] i_req,
    input  wire logic       i_advance,
    output logic            o_valid,
    output logic            o_gnt
);

    logic r_last;

    // Grant decision for the current cycle.
    always_comb begin
        o_valid = |i_req;
        o_gnt   = rr_pick(i_req, r_last);
    end

    // Last-granted register; reset to the icache so the dcache wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= GNT_I;
        end else if (i_advance && o_valid) begin
            r_last <= o_gnt;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one backing memory between the icache and dcache refill
//             ports. Round-robin grant, registered address/command/data,
//             one memory transaction at a time, ready/data routed back to the
//             winner, and a watchdog that force-completes a hung transaction.
//  Revision : 1.0 - initial release
// ============================================================================
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
    parameter int          TIMEOUT  = 255,
    parameter int          CNT_W    = 8,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mem_port_arbiter_if.slave   ic,
    mem_port_arbiter_if.slave   dc,
    mem_port_arbiter_if.master  mem,
    output logic                o_err,
    output logic [1:0]          o_state
);

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

    state_t             r_state,  w_state_nx;
    logic               r_gnt,    w_gnt_nx;
    logic [31:0]        r_addr,   w_addr_nx;
    logic               r_we,     w_we_nx;
    logic [31:0]        r_wd,     w_wd_nx;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_nx;
    logic               r_err,    w_err_nx;

    logic               w_arb_valid;
    logic               w_arb_gnt;
    logic               w_advance;
    logic               w_done;
    logic               w_timeout;
    logic [31:0]        w_rd;

    // The round-robin history is advanced at grant time rather than at
    // completion. The grant is latched for the whole transaction and the
    // history is only consulted in IDLE, so both choices give identical
    // arbitration, and this keeps the arbiter independent of the latched id.
    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     ({dc.req, ic.req}),
        .i_advance (w_advance),
        .o_valid   (w_arb_valid),
        .o_gnt     (w_arb_gnt)
    );

    assign w_timeout = (r_cnt == C_TIMEOUT);

    // Next-state, latch updates, watchdog and memory-side outputs.
    always_comb begin
        w_state_nx = r_state;
        w_gnt_nx   = r_gnt;
        w_addr_nx  = r_addr;
        w_we_nx    = r_we;
        w_wd_nx    = r_wd;
        w_cnt_nx   = r_cnt;
        w_err_nx   = r_err;
        w_advance  = 1'b0;
        w_done     = 1'b0;
        w_rd       = 32'h0;
        mem.req    = 1'b0;
        mem.we     = 1'b0;
        mem.wd     = 32'h0;

        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_advance  = 1'b1;
                    w_gnt_nx   = w_arb_gnt;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_BUSY;
                    if (w_arb_gnt == GNT_D) begin
                        w_addr_nx = dc.addr;
                        w_we_nx   = dc.we;
                        w_wd_nx   = dc.wd;
                    end else begin
                        w_addr_nx = ic.addr;
                        w_we_nx   = ic.we;
                        w_wd_nx   = ic.wd;
                    end
                end
            end

            ST_BUSY: begin
                mem.req = 1'b1;
                mem.we  = r_we;
                mem.wd  = r_wd;
                if (mem.ready) begin
                    // A real completion beats a simultaneous timeout.
                    w_done     = 1'b1;
                    w_rd       = mem.rd;
                    w_state_nx = ST_RECOVER;
                end else if (w_timeout) begin
                    w_done     = 1'b1;
                    w_rd       = ERR_DATA;
                    w_err_nx   = 1'b1;
                    w_state_nx = ST_RECOVER;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end

            // One dead cycle so a cache can drop its request after Ready
            // before IDLE samples it again.
            ST_RECOVER: begin
                w_state_nx = ST_IDLE;
            end

            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Completion routing: only the granted port ever sees ready or data.
    always_comb begin
        ic.ready = w_done && (r_gnt == GNT_I);
        dc.ready = w_done && (r_gnt == GNT_D);
        ic.rd    = ic.ready ? w_rd : 32'h0;
        dc.rd    = dc.ready ? w_rd : 32'h0;
    end

    assign mem.addr = r_addr;
    assign o_err    = r_err;
    assign o_state  = r_state;

    // State, latched transaction and watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= GNT_I;
            r_addr  <= 32'h0;
            r_we    <= 1'b0;
            r_wd    <= 32'h0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_gnt   <= w_gnt_nx;
            r_addr  <= w_addr_nx;
            r_we    <= w_we_nx;
            r_wd    <= w_wd_nx;
            r_cnt   <= w_cnt_nx;
            r_err   <= w_err_nx;
        end
    end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter with a
//             behavioural memory and a completion scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
import mem_port_arbiter_pkg::*;

module tb_mem_port_arbiter;

    localparam int TMO = 8;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic       err;
    logic [1:0] st;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    exp_t mon_e;

    // Behavioural memory controls.
    int          mem_lat  = 1;
    bit          mem_hang = 1'b0;
    logic [31:0] mem_base = 32'h0;
    int          mcnt     = 0;
    int          n;

    always #5 clk = ~clk;

    mem_port_arbiter_if ic ();
    mem_port_arbiter_if dc ();
    mem_port_arbiter_if mem ();

    mem_port_arbiter #(
        .TIMEOUT  (TMO),
        .CNT_W    (8),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ic      (ic),
        .dc      (dc),
        .mem     (mem),
        .o_err   (err),
        .o_state (st)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory answers mem_lat cycles into a request (cycle 1 = first MReq
    // cycle) with data derived from the address; junk data otherwise.
    always @(posedge clk) begin
        #2;
        if (mem.req) begin
            mcnt++;
            mem.ready = !mem_hang && (mcnt == mem_lat);
            mem.rd    = mem.ready ? (mem_base ^ mem.addr) : $urandom;
        end else begin
            mcnt      = 0;
            mem.ready = 1'b0;
            mem.rd    = $urandom;
        end
    end

    // Scoreboard: every ready pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!ic.ready) chk("i_rd_gated", ic.rd, 32'h0);
            if (!dc.ready) chk("d_rd_gated", dc.rd, 32'h0);
            if (ic.ready || dc.ready) begin
                n_cmp++;
                assert (q.size() != 0) else begin
                    n_bad++;
                    $error("FAIL unexpected_ready: observed i=%b d=%b expected no ready", ic.ready, dc.ready);
                end
                if (q.size() != 0) begin
                    mon_e = q.pop_front();
                    chk("ready_port", {30'b0, ic.ready, dc.ready},
                        (mon_e.port == GNT_D) ? 32'h1 : 32'h2);
                    chk("ready_data", (mon_e.port == GNT_D) ? dc.rd : ic.rd, mon_e.data);
                end
            end
        end
    end

    task automatic idle_inputs();
        ic.req = 1'b0; ic.addr = 32'h0; ic.we = 1'b0; ic.wd = 32'h0;
        dc.req = 1'b0; dc.addr = 32'h0; dc.we = 1'b0; dc.wd = 32'h0;
    endtask

    // Follows one transaction from the cycle its request is presented in
    // IDLE; checks the memory side each BUSY cycle; returns cycles to ready.
    task automatic wait_txn(input string tag, input logic [31:0] a, input logic we,
                            input logic [31:0] wd, input int max, output int cyc);
        bit done = 1'b0;
        cyc = 0;
        for (int k = 0; k < max && !done; k++) begin
            @(negedge clk);
            cyc++;
            chk({tag, "_state"}, {30'b0, st}, {30'b0, ST_BUSY});
            chk({tag, "_mreq"},  {31'b0, mem.req}, 32'h1);
            chk({tag, "_maddr"}, mem.addr, a);
            chk({tag, "_mwe"},   {31'b0, mem.we}, {31'b0, we});
            chk({tag, "_mwd"},   mem.wd, wd);
            if (ic.ready || dc.ready) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s_no_ready: observed no ready in %0d cycles expected a ready", tag, max);
        end
    endtask

    task automatic chk_recover_idle(input string tag, input logic exp_err);
        @(negedge clk);
        chk({tag, "_recover"}, {30'b0, st}, {30'b0, ST_RECOVER});
        chk({tag, "_rec_mreq"}, {31'b0, mem.req}, 32'h0);
        chk({tag, "_rec_mwe"}, {31'b0, mem.we}, 32'h0);
        chk({tag, "_rec_mwd"}, mem.wd, 32'h0);
        chk({tag, "_rec_err"}, {31'b0, err}, {31'b0, exp_err});
        @(negedge clk);
        chk({tag, "_idle"}, {30'b0, st}, {30'b0, ST_IDLE});
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", {30'b0, st}, 32'h0);
        chk("rst_mreq",  {31'b0, mem.req}, 32'h0);
        chk("rst_mwe",   {31'b0, mem.we}, 32'h0);
        chk("rst_mwd",   mem.wd, 32'h0);
        chk("rst_maddr", mem.addr, 32'h0);
        chk("rst_err",   {31'b0, err}, 32'h0);
        chk("rst_iready", {31'b0, ic.ready}, 32'h0);
        chk("rst_dready", {31'b0, dc.ready}, 32'h0);
        rst_n = 1'b1;

        // 1: single icache read, memory latency 4.
        mem_lat  = 4;
        mem_base = 32'h1234_5678 ^ 32'h40;
        ic.req = 1'b1; ic.addr = 32'h40; ic.we = 1'b0;
        q.push_back('{GNT_I, 32'h1234_5678});
        wait_txn("t1", 32'h40, 1'b0, 32'h0, 20, n);
        chk("t1_latency", n, 4);
        chk("t1_dready", {31'b0, dc.ready}, 32'h0);
        ic.req = 1'b0;
        chk_recover_idle("t1", 1'b0);

        // 2: continuous tie from reset release, latency 2 -> d, i, d.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_lat  = 2;
        mem_base = 32'hA5A5_0000;
        ic.req = 1'b1; ic.addr = 32'h200;
        dc.req = 1'b1; dc.addr = 32'h300;
        q.push_back('{GNT_D, 32'hA5A5_0000 ^ 32'h300});
        q.push_back('{GNT_I, 32'hA5A5_0000 ^ 32'h200});
        q.push_back('{GNT_D, 32'hA5A5_0000 ^ 32'h300});
        for (int k = 0; k < 3; k++) begin
            wait_txn("t2", (k == 1) ? 32'h200 : 32'h300, 1'b0, 32'h0, 10, n);
            chk("t2_latency", n, 2);
            if (k == 2) begin
                ic.req = 1'b0;
                dc.req = 1'b0;
            end
            chk_recover_idle("t2", 1'b0);
        end

        // 3: dcache write; request and data change right after grant.
        mem_lat  = 3;
        mem_base = 32'h0BAD_0000;
        dc.req = 1'b1; dc.we = 1'b1; dc.addr = 32'h100; dc.wd = 32'hCAFE;
        q.push_back('{GNT_D, 32'h0BAD_0000 ^ 32'h100});
        @(negedge clk);
        chk("t3_state", {30'b0, st}, {30'b0, ST_BUSY});
        chk("t3_mwd_first", mem.wd, 32'hCAFE);
        dc.req = 1'b0; dc.we = 1'b0; dc.wd = 32'h0;
        wait_txn("t3", 32'h100, 1'b1, 32'hCAFE, 10, n);
        chk("t3_latency", n, 2);
        chk_recover_idle("t3", 1'b0);

        // 4: hung memory -> forced error completion after TMO+1 BUSY cycles.
        mem_hang = 1'b1;
        ic.req = 1'b1; ic.addr = 32'h44;
        q.push_back('{GNT_I, 32'hDEADBEEF});
        wait_txn("t4", 32'h44, 1'b0, 32'h0, 20, n);
        ic.req = 1'b0;
        chk("t4_latency", n, TMO + 1);
        chk_recover_idle("t4", 1'b1);
        mem_hang = 1'b0;
        mem_lat  = 2;
        mem_base = 32'h600D_0000;
        dc.req = 1'b1; dc.addr = 32'h80;
        q.push_back('{GNT_D, 32'h600D_0000 ^ 32'h80});
        wait_txn("t4b", 32'h80, 1'b0, 32'h0, 10, n);
        dc.req = 1'b0;
        chk("t4b_err_sticky", {31'b0, err}, 32'h1);
        chk_recover_idle("t4b", 1'b1);

        // 5: asynchronous reset mid-transaction, then a fresh tie.
        mem_hang = 1'b1;
        dc.req = 1'b1; dc.we = 1'b1; dc.addr = 32'h500; dc.wd = 32'h1234;
        @(negedge clk);
        dc.req = 1'b0;
        @(negedge clk);
        chk("t5_busy", {30'b0, st}, {30'b0, ST_BUSY});
        chk("t5_mwe", {31'b0, mem.we}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_mreq",  {31'b0, mem.req}, 32'h0);
        chk("t5_async_mwe",   {31'b0, mem.we}, 32'h0);
        chk("t5_async_mwd",   mem.wd, 32'h0);
        chk("t5_async_state", {30'b0, st}, 32'h0);
        chk("t5_async_err",   {31'b0, err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_hang = 1'b0;
        mem_lat  = 1;
        dc.we = 1'b0; dc.wd = 32'h0;
        repeat (3) begin
            @(negedge clk);
            chk("t5_stay_idle", {30'b0, st}, {30'b0, ST_IDLE});
        end
        mem_base = 32'h7E57_0000;
        ic.req = 1'b1; ic.addr = 32'h700;
        dc.req = 1'b1; dc.addr = 32'h780;
        q.push_back('{GNT_D, 32'h7E57_0000 ^ 32'h780});
        wait_txn("t5", 32'h780, 1'b0, 32'h0, 10, n);
        chk("t5_latency", n, 1);
        ic.req = 1'b0;
        dc.req = 1'b0;
        chk_recover_idle("t5", 1'b0);

        // 6: memory ready in the same cycle the watchdog expires.
        mem_lat  = TMO + 1;
        mem_base = 32'h5EED_0000;
        ic.req = 1'b1; ic.addr = 32'h60;
        q.push_back('{GNT_I, 32'h5EED_0000 ^ 32'h60});
        wait_txn("t6", 32'h60, 1'b0, 32'h0, 20, n);
        ic.req = 1'b0;
        chk("t6_latency", n, TMO + 1);
        chk_recover_idle("t6", 1'b0);

        repeat (2) @(negedge clk);
        chk("queue_empty", q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
